ps2_kb_rx_fifo: RTL and testbench

//  Parametrised PS/2 keyboard receiver: synchronises and filters PS2_clk/PS2_data, deframes
//  11-bit frames, checks odd parity and stop bit, tags break (F0-prefixed) codes, and queues

---
 rtl/ps2_kb_rx_fifo_pkg.sv | 21 ++
 rtl/ps2_sync_filter.sv | 49 ++++
 rtl/ps2_kb_rx_fifo.sv | 177 +++++++++++++++++
 tb/tb_ps2_kb_rx_fifo.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kb_rx_fifo_pkg.sv
// Shared constants, FSM state type and the parity helper for the PS/2 keyboard receiver.
package ps2_kb_rx_fifo_pkg;

    // Data bits carried by every PS/2 frame (start, 8 data, parity, stop).
    localparam int         CODE_BITS  = 8;
    // Prefix byte the keyboard sends ahead of a key-release scancode.
    localparam logic [7:0] BREAK_CODE = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    // PS/2 uses odd parity: data bits plus the parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] code, input logic par);
        return ^{code, par};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser plus stability filter for one raw PS/2 line.
// level follows the raw input only after it has held a new value for FILTER_LEN
// clocks; fall pulses for one clock in the cycle level drops from 1 to 0.
module ps2_sync_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam int CNT_W = $clog2(FILTER_LEN) + 1;

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous pin into the clk domain; idle PS/2 lines are high.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], raw};
        end
    end

    // Accept a new level only after it has been stable for FILTER_LEN cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
                level <= sync[1];
                cnt   <= '0;
                fall  <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_kb_rx_fifo.sv
// PS/2 keyboard receiver: filtered pin sampling, 11-bit frame deframer with parity,
// stop-bit and timeout checking, break-code tagging, and a first-word fall-through FIFO.
module ps2_kb_rx_fifo
    import ps2_kb_rx_fifo_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 100000,
    parameter int TAG_BREAK   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PS2_clk,
    input  logic              PS2_data,
    input  logic              KB_read_en,
    input  logic              KB_clear,
    output logic              KB_status,
    output logic [DATA_W-1:0] KB_data,
    output logic              KB_break,
    output logic              buf_full,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overflow
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

    // ---------------- pin conditioning ----------------
    logic ps2_clk_lvl, ps2_clk_fall;
    logic ps2_data_lvl;
    // Edges of the data line carry no meaning; only its level at a clock fall is used.
    logic data_fall_unused;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (PS2_clk),
        .level (ps2_clk_lvl),
        .fall  (ps2_clk_fall)
    );

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (PS2_data),
        .level (ps2_data_lvl),
        .fall  (data_fall_unused)
    );

    // ---------------- deframer ----------------
    rx_state_t         state;
    logic [7:0]        shreg;
    logic [2:0]        bit_cnt;
    logic              par_bit;
    logic [TO_W-1:0]   to_cnt;
    logic              break_pend;
    logic              push_valid;
    logic [DATA_W-1:0] push_code;
    logic              push_break;

    // Frame FSM: shift bits on filtered clock falls, validate at the stop bit, flag errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            break_pend <= 1'b0;
            push_valid <= 1'b0;
            push_code  <= '0;
            push_break <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else if (KB_clear) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            break_pend <= 1'b0;
            push_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            push_valid <= 1'b0;
            if (state == ST_IDLE) begin
                if (ps2_clk_fall) begin
                    if (!ps2_data_lvl) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                        to_cnt  <= '0;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end else if (ps2_clk_fall) begin
                to_cnt <= '0;
                case (state)
                    ST_DATA: begin
                        shreg   <= {ps2_data_lvl, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'(CODE_BITS - 1)) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_bit <= ps2_data_lvl;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (!ps2_data_lvl) begin
                            frame_err <= 1'b1;
                        end else if (!odd_parity_ok(shreg, par_bit)) begin
                            parity_err <= 1'b1;
                        end else if (TAG_BREAK != 0 && shreg == BREAK_CODE) begin
                            break_pend <= 1'b1;
                        end else begin
                            push_valid <= 1'b1;
                            push_code  <= shreg[DATA_W-1:0];
                            push_break <= break_pend;
                            break_pend <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                state     <= ST_IDLE;
                to_cnt    <= '0;
                frame_err <= 1'b1;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // ---------------- FIFO ----------------
    logic [DATA_W:0] mem [FIFO_DEPTH];
    logic [ADDR_W:0] wr_ptr, rd_ptr;
    logic            empty, full, do_push, do_pop;
    logic [DATA_W:0] head;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign do_pop  = KB_read_en && !empty;
    assign do_push = push_valid && (!full || do_pop);

    // Pointer and overflow bookkeeping; clear wins over any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else if (KB_clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push_valid && full && !do_pop) overflow <= 1'b1;
        end
    end

    // Entry storage written on push.
    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= {push_break, push_code};
    end

    assign head      = mem[rd_ptr[ADDR_W-1:0]];
    assign KB_status = !empty;
    assign KB_data   = empty ? '0 : head[DATA_W-1:0];
    assign KB_break  = !empty && head[DATA_W];
    assign buf_full  = full;

endmodule

// File: tb/tb_ps2_kb_rx_fifo.sv
// Self-checking bench for ps2_kb_rx_fifo: table of frames plus hand-built corner cases,
// with a scoreboard queue of expected FIFO entries.
module tb_ps2_kb_rx_fifo;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;
    localparam int FILT    = 4;
    localparam int TOUT    = 2000;
    localparam int HALF    = 20;
    localparam int NVEC    = 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ps2_clk = 1'b1;
    logic              ps2_data = 1'b1;
    logic              read_en = 1'b0;
    logic              clear = 1'b0;
    logic              kb_status;
    logic [DATA_W-1:0] kb_data;
    logic              kb_break;
    logic              buf_full;
    logic              parity_err;
    logic              frame_err;
    logic              overflow;

    always #5 clk = ~clk;

    ps2_kb_rx_fifo #(
        .DATA_W      (DATA_W),
        .FIFO_DEPTH  (DEPTH),
        .FILTER_LEN  (FILT),
        .TIMEOUT_CYC (TOUT),
        .TAG_BREAK   (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PS2_clk    (ps2_clk),
        .PS2_data   (ps2_data),
        .KB_read_en (read_en),
        .KB_clear   (clear),
        .KB_status  (kb_status),
        .KB_data    (kb_data),
        .KB_break   (kb_break),
        .buf_full   (buf_full),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    typedef struct {
        logic [7:0] code;
        bit         par_ok;
        bit         stop_ok;
    } vec_t;

    typedef struct packed {
        logic       brk;
        logic [7:0] code;
    } ent_t;

    vec_t vecs [NVEC];
    ent_t q [$];
    int   n_vec = 0;
    int   n_fail = 0;
    bit   m_brk = 1'b0, m_par = 1'b0, m_frm = 1'b0, m_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for the receiver's filtered PS/2 clock fall, used as a timing reference.
    task automatic wait_fall(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dut.ps2_clk_fall) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // mode 0: plain frame; 1: check 2-cycle push latency; 2: pop during the push cycle.
    task automatic send_frame(input logic [7:0] code, input bit par_ok, input bit stop_ok,
                              input int nbits, input int mode);
        logic [10:0] frm;
        bit          ok;
        ent_t        e;
        frm = {stop_ok, (par_ok ? ~^code : ^code), code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frm[i];
            cyc(HALF);
            ps2_clk = 1'b0;
            if (i == 10 && mode != 0) begin
                wait_fall(ok);
                check("stop_fall_seen", 32'(ok), 1);
                if (mode == 1) begin
                    check("lat_at_fall", 32'(kb_status), 0);
                    cyc(1);
                    check("lat_plus1", 32'(kb_status), 0);
                    cyc(1);
                    check("lat_plus2", 32'(kb_status), 1);
                end else begin
                    cyc(1);
                    check("pp_head", 32'(kb_data), 32'(q[0].code));
                    e = q.pop_front();
                    read_en = 1'b1;
                    cyc(1);
                    read_en = 1'b0;
                    check("pp_full_kept", 32'(buf_full), 1);
                    check("pp_no_ovf", 32'(overflow), 0);
                end
            end
            cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        cyc(HALF);
    endtask

    // Reference model of frame acceptance, break tagging and overflow.
    task automatic model_frame(input logic [7:0] code, input bit par_ok, input bit stop_ok);
        if (!stop_ok) begin
            m_frm = 1'b1;
        end else if (!par_ok) begin
            m_par = 1'b1;
        end else if (code == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (q.size() == DEPTH) m_ovf = 1'b1;
            else q.push_back({m_brk, code});
            m_brk = 1'b0;
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_parity_err"}, 32'(parity_err), 32'(m_par));
        check({tag, "_frame_err"},  32'(frame_err),  32'(m_frm));
        check({tag, "_overflow"},   32'(overflow),   32'(m_ovf));
        check({tag, "_buf_full"},   32'(buf_full),   32'(q.size() == DEPTH));
    endtask

    task automatic pulse_read();
        read_en = 1'b1;
        cyc(1);
        read_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        ent_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            check({tag, "_status"}, 32'(kb_status), 1);
            check({tag, "_data"},   32'(kb_data),   32'(e.code));
            check({tag, "_break"},  32'(kb_break),  32'(e.brk));
            pulse_read();
        end
        check({tag, "_empty_status"}, 32'(kb_status), 0);
        check({tag, "_empty_data"},   32'(kb_data),   0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        m_brk = 1'b0;
        m_par = 1'b0;
        m_frm = 1'b0;
        m_ovf = 1'b0;
        q.delete();
        cyc(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h33, 1'b1, 1'b1};
        vecs[1] = '{8'hF0, 1'b1, 1'b1};
        vecs[2] = '{8'h1C, 1'b1, 1'b1};
        vecs[3] = '{8'h33, 1'b0, 1'b1};
        vecs[4] = '{8'h1C, 1'b1, 1'b1};
        vecs[5] = '{8'h5A, 1'b1, 1'b0};
        vecs[6] = '{8'hA5, 1'b1, 1'b1};
        vecs[7] = '{8'h00, 1'b1, 1'b1};
        vecs[8] = '{8'hFF, 1'b1, 1'b1};

        // Reset state, observed while reset is still asserted.
        cyc(3);
        check("rst_status", 32'(kb_status), 0);
        check("rst_data",   32'(kb_data),   0);
        check("rst_break",  32'(kb_break),  0);
        check_flags("rst");
        rst_n = 1'b1;
        cyc(2);

        // First frame into an empty FIFO: status rises exactly 2 clocks after the stop fall.
        send_frame(8'h33, 1'b1, 1'b1, 11, 1);
        model_frame(8'h33, 1'b1, 1'b1);
        check_flags("lat");
        drain("lat");

        // Table of frames: good, break-prefixed, bad parity, bad stop.
        for (int v = 0; v < NVEC; v++) begin
            send_frame(vecs[v].code, vecs[v].par_ok, vecs[v].stop_ok, 11, 0);
            model_frame(vecs[v].code, vecs[v].par_ok, vecs[v].stop_ok);
            check_flags($sformatf("vec%0d", v));
            drain($sformatf("vec%0d", v));
        end

        // Truncated frame: start + 4 data bits, then PS2_clk stops.
        do_clear();
        check_flags("clr1");
        send_frame(8'h55, 1'b1, 1'b1, 5, 0);
        cyc(TOUT + 10);
        m_frm = 1'b1;
        check_flags("tout");
        send_frame(8'h33, 1'b1, 1'b1, 11, 0);
        model_frame(8'h33, 1'b1, 1'b1);
        check_flags("tout_next");
        drain("tout_next");

        // KB_clear held through a whole frame: frame ignored, sticky errors cleared.
        clear = 1'b1;
        send_frame(8'h33, 1'b1, 1'b1, 11, 0);
        clear = 1'b0;
        m_par = 1'b0;
        m_frm = 1'b0;
        m_ovf = 1'b0;
        m_brk = 1'b0;
        cyc(2);
        check_flags("hold_clr");
        check("hold_clr_status", 32'(kb_status), 0);

        // FIFO_DEPTH+1 frames: last one dropped with overflow.
        for (int i = 1; i <= DEPTH + 1; i++) begin
            send_frame(8'(i), 1'b1, 1'b1, 11, 0);
            model_frame(8'(i), 1'b1, 1'b1);
        end
        check_flags("ovf");
        drain("ovf");
        check_flags("ovf_drained");

        // Full FIFO with a pop in the push cycle: both happen, no overflow.
        do_clear();
        for (int i = 1; i <= DEPTH; i++) begin
            send_frame(8'(i), 1'b1, 1'b1, 11, 0);
            model_frame(8'(i), 1'b1, 1'b1);
        end
        check_flags("pp_pre");
        send_frame(8'h20, 1'b1, 1'b1, 11, 2);
        model_frame(8'h20, 1'b1, 1'b1);
        check_flags("pp_post");
        check("pp_head_next", 32'(kb_data), 32'(q[0].code));

        // Clear flushes everything.
        do_clear();
        check("clr_status", 32'(kb_status), 0);
        check("clr_data",   32'(kb_data),   0);
        check("clr_break",  32'(kb_break),  0);
        check_flags("clr2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
